// File: rtl/if_stage.sv
// Instruction fetch stage with IF/ID pipeline register, one-entry skid buffer and redirect drain.
// Optional IF_PERF_EN adds fetch and bubble counters.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_data,
  output logic [31:0] if_id_IR,
  output logic [31:0] if_id_PC,
  output logic        if_id_valid_inst
`ifdef IF_PERF_EN
  ,
  output logic [31:0] if_fetch_cnt,
  output logic [31:0] if_bubble_cnt
`endif
);

  localparam int unsigned XLEN = 32;

  typedef enum logic {RUN, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]   drain_addr_q, drain_addr_d;
  logic              skid_full_q, skid_full_d;
  logic [XLEN-1:0]   skid_inst_q, skid_inst_d;
  logic [XLEN-1:0]   skid_pc_q, skid_pc_d;
  logic [XLEN-1:0]   ir_q, ir_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              valid_q, valid_d;
  logic              done;
  logic [XLEN-1:0]   pc_plus4;

  // Request is held off only by reset or a full skid, so it can never drop mid-transaction.
  assign imem_req  = !rst && !skid_full_q;
  assign imem_addr = (state_q == DRAIN) ? drain_addr_q : fetch_pc_q;
  assign done      = imem_req && imem_valid;
  assign pc_plus4  = fetch_pc_q + XLEN'(4);

  assign if_id_IR         = ir_q;
  assign if_id_PC         = pc_q;
  assign if_id_valid_inst = valid_q;

  // Next-state and datapath: redirect > stall > normal.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    drain_addr_d = drain_addr_q;
    skid_full_d  = skid_full_q;
    skid_inst_d  = skid_inst_q;
    skid_pc_d    = skid_pc_q;
    ir_d         = ir_q;
    pc_d         = pc_q;
    valid_d      = valid_q;

    if (redirect_en) begin
      valid_d     = 1'b0;
      ir_d        = NOP_INST;
      skid_full_d = 1'b0;
      fetch_pc_d  = redirect_pc & ~XLEN'(3);
      if (imem_req && !imem_valid) begin
        drain_addr_d = imem_addr;
        state_d      = DRAIN;
      end else begin
        state_d = RUN;
      end
    end else if (state_q == DRAIN) begin
      valid_d = 1'b0;
      ir_d    = NOP_INST;
      if (done) state_d = RUN;
    end else if (stall) begin
      if (done) begin
        skid_full_d = 1'b1;
        skid_inst_d = imem_data;
        skid_pc_d   = fetch_pc_q;
        fetch_pc_d  = pc_plus4;
      end
    end else if (skid_full_q) begin
      ir_d        = skid_inst_q;
      pc_d        = skid_pc_q;
      valid_d     = 1'b1;
      skid_full_d = 1'b0;
    end else if (done) begin
      ir_d       = imem_data;
      pc_d       = fetch_pc_q;
      valid_d    = 1'b1;
      fetch_pc_d = pc_plus4;
    end else begin
      ir_d    = NOP_INST;
      valid_d = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      fetch_pc_q   <= RESET_PC;
      drain_addr_q <= '0;
      skid_full_q  <= 1'b0;
      skid_inst_q  <= '0;
      skid_pc_q    <= '0;
      ir_q         <= NOP_INST;
      pc_q         <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      drain_addr_q <= drain_addr_d;
      skid_full_q  <= skid_full_d;
      skid_inst_q  <= skid_inst_d;
      skid_pc_q    <= skid_pc_d;
      ir_q         <= ir_d;
      pc_q         <= pc_d;
      valid_q      <= valid_d;
    end
  end

`ifdef IF_PERF_EN
  logic [XLEN-1:0] fetch_cnt_q;
  logic [XLEN-1:0] bubble_cnt_q;

  assign if_fetch_cnt  = fetch_cnt_q;
  assign if_bubble_cnt = bubble_cnt_q;

  // A fetch counts only if its data is kept (not dropped by a redirect or drain).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (done && !redirect_en && state_q == RUN) fetch_cnt_q <= fetch_cnt_q + XLEN'(1);
      if (!valid_q) bubble_cnt_q <= bubble_cnt_q + XLEN'(1);
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage with a configurable-latency instruction memory.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_data;
  logic [31:0] if_id_IR;
  logic [31:0] if_id_PC;
  logic        if_id_valid_inst;
`ifdef IF_PERF_EN
  logic [31:0] if_fetch_cnt;
  logic [31:0] if_bubble_cnt;
`endif

  int checks;
  int errors;
  int wait_cycles;
  int wcnt;

  if_stage dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .redirect_en(redirect_en),
    .redirect_pc(redirect_pc),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_valid(imem_valid),
    .imem_data(imem_data),
    .if_id_IR(if_id_IR),
    .if_id_PC(if_id_PC),
    .if_id_valid_inst(if_id_valid_inst)
`ifdef IF_PERF_EN
    ,
    .if_fetch_cnt(if_fetch_cnt),
    .if_bubble_cnt(if_bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst(input logic [31:0] a);
    return 32'hAB00_0000 | a;
  endfunction

  // Memory model: responds after wait_cycles cycles of a held request.
  assign imem_valid = (wcnt >= wait_cycles);
  assign imem_data  = inst(imem_addr);

  always @(posedge clk) begin
    if (rst || !imem_req || imem_valid) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int w);
    rst = 1'b1;
    stall = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = 32'h0;
    wait_cycles = w;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    stall = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = 32'h0;
    wait_cycles = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", imem_req); end
    checks++; if (if_id_valid_inst !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", if_id_valid_inst); end
    checks++; if (if_id_IR !== NOP) begin errors++; $display("FAIL rst_ir got %h exp %h", if_id_IR, NOP); end
    checks++; if (if_id_PC !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", if_id_PC); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rst_first_req got %b exp 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_first_addr got %h exp 0", imem_addr); end
  endtask

  task automatic test_zero_wait();
    do_reset(0);
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (if_id_valid_inst !== 1'b1) begin errors++; $display("FAIL zw_valid[%0d] got %b exp 1", i, if_id_valid_inst); end
      checks++; if (if_id_PC !== 32'(4 * i)) begin errors++; $display("FAIL zw_pc[%0d] got %h exp %h", i, if_id_PC, 32'(4 * i)); end
      checks++; if (if_id_IR !== inst(32'(4 * i))) begin errors++; $display("FAIL zw_ir[%0d] got %h exp %h", i, if_id_IR, inst(32'(4 * i))); end
    end
`ifdef IF_PERF_EN
    checks++; if (if_fetch_cnt !== 32'd5) begin errors++; $display("FAIL zw_fetch_cnt got %0d exp 5", if_fetch_cnt); end
    checks++; if (if_bubble_cnt !== 32'd1) begin errors++; $display("FAIL zw_bubble_cnt got %0d exp 1", if_bubble_cnt); end
`endif
  endtask

  task automatic test_wait2();
    do_reset(2);
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 2; k++) begin
        step();
        checks++; if (imem_addr !== 32'(4 * r)) begin errors++; $display("FAIL w2_addr[%0d.%0d] got %h exp %h", r, k, imem_addr, 32'(4 * r)); end
        checks++; if (if_id_valid_inst !== 1'b0 || if_id_IR !== NOP) begin errors++; $display("FAIL w2_bubble[%0d.%0d] got v=%b ir=%h exp v=0 ir=%h", r, k, if_id_valid_inst, if_id_IR, NOP); end
      end
      step();
      checks++; if (if_id_valid_inst !== 1'b1 || if_id_PC !== 32'(4 * r) || if_id_IR !== inst(32'(4 * r))) begin
        errors++; $display("FAIL w2_inst[%0d] got v=%b pc=%h ir=%h exp v=1 pc=%h", r, if_id_valid_inst, if_id_PC, if_id_IR, 32'(4 * r));
      end
    end
  endtask

  task automatic test_stall();
    do_reset(0);
    step();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (if_id_PC !== 32'h0 || if_id_valid_inst !== 1'b1 || if_id_IR !== inst(32'h0)) begin
        errors++; $display("FAIL st_hold[%0d] got v=%b pc=%h exp v=1 pc=0", k, if_id_valid_inst, if_id_PC);
      end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL st_req[%0d] got %b exp 0", k, imem_req); end
    end
    stall = 1'b0;
    step();
    checks++; if (if_id_PC !== 32'h4 || if_id_valid_inst !== 1'b1 || if_id_IR !== inst(32'h4)) begin
      errors++; $display("FAIL st_skid got v=%b pc=%h ir=%h exp v=1 pc=4", if_id_valid_inst, if_id_PC, if_id_IR);
    end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL st_next_req got req=%b addr=%h exp req=1 addr=8", imem_req, imem_addr); end
    step();
    checks++; if (if_id_PC !== 32'h8 || if_id_valid_inst !== 1'b1) begin errors++; $display("FAIL st_after got v=%b pc=%h exp v=1 pc=8", if_id_valid_inst, if_id_PC); end
  endtask

  task automatic test_redirect_drain();
    do_reset(0);
    repeat (8) step();
    wait_cycles = 3;
    step();
    checks++; if (imem_addr !== 32'h20 || imem_req !== 1'b1) begin errors++; $display("FAIL rd_pre got req=%b addr=%h exp req=1 addr=20", imem_req, imem_addr); end
    redirect_en = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect_en = 1'b0;
    checks++; if (imem_addr !== 32'h20) begin errors++; $display("FAIL rd_hold1 got %h exp 20", imem_addr); end
    checks++; if (if_id_valid_inst !== 1'b0 || if_id_IR !== NOP) begin errors++; $display("FAIL rd_flush got v=%b ir=%h exp v=0 ir=%h", if_id_valid_inst, if_id_IR, NOP); end
    step();
    checks++; if (imem_addr !== 32'h20 || imem_valid !== 1'b1) begin errors++; $display("FAIL rd_hold2 got addr=%h mv=%b exp addr=20 mv=1", imem_addr, imem_valid); end
    step();
    checks++; if (imem_addr !== 32'h100 || imem_req !== 1'b1) begin errors++; $display("FAIL rd_refetch got req=%b addr=%h exp req=1 addr=100", imem_req, imem_addr); end
    checks++; if (if_id_valid_inst !== 1'b0) begin errors++; $display("FAIL rd_discard got v=%b exp 0", if_id_valid_inst); end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (if_id_valid_inst !== 1'b0) begin errors++; $display("FAIL rd_wait[%0d] got v=%b exp 0", k, if_id_valid_inst); end
    end
    step();
    checks++; if (if_id_valid_inst !== 1'b1 || if_id_PC !== 32'h100 || if_id_IR !== inst(32'h100)) begin
      errors++; $display("FAIL rd_target got v=%b pc=%h ir=%h exp v=1 pc=100", if_id_valid_inst, if_id_PC, if_id_IR);
    end
  endtask

  task automatic test_redirect_stall();
    do_reset(0);
    step();
    stall = 1'b1;
    step();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rs_full got req=%b exp 0", imem_req); end
    redirect_en = 1'b1;
    redirect_pc = 32'h202;
    step();
    redirect_en = 1'b0;
    stall = 1'b0;
    checks++; if (if_id_valid_inst !== 1'b0 || if_id_IR !== NOP || if_id_PC !== 32'h0) begin
      errors++; $display("FAIL rs_flush got v=%b ir=%h pc=%h exp v=0 ir=%h pc=0", if_id_valid_inst, if_id_IR, if_id_PC, NOP);
    end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL rs_req got req=%b addr=%h exp req=1 addr=200", imem_req, imem_addr); end
    step();
    checks++; if (if_id_valid_inst !== 1'b1 || if_id_PC !== 32'h200) begin errors++; $display("FAIL rs_target got v=%b pc=%h exp v=1 pc=200", if_id_valid_inst, if_id_PC); end
  endtask

  task automatic test_wrap();
    do_reset(0);
    step();
    redirect_en = 1'b1;
    redirect_pc = 32'hFFFF_FFFD;
    step();
    redirect_en = 1'b0;
    checks++; if (if_id_valid_inst !== 1'b0 || imem_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wr_redir got v=%b addr=%h exp v=0 addr=fffffffc", if_id_valid_inst, imem_addr);
    end
    step();
    checks++; if (if_id_PC !== 32'hFFFF_FFFC || if_id_valid_inst !== 1'b1) begin errors++; $display("FAIL wr_last got v=%b pc=%h exp v=1 pc=fffffffc", if_id_valid_inst, if_id_PC); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wr_addr got %h exp 0", imem_addr); end
    step();
    checks++; if (if_id_PC !== 32'h0 || if_id_IR !== inst(32'h0)) begin errors++; $display("FAIL wr_zero got pc=%h ir=%h exp pc=0", if_id_PC, if_id_IR); end
  endtask

  task automatic test_async_reset();
    do_reset(0);
    step();
    step();
    checks++; if (if_id_PC !== 32'h4 || if_id_valid_inst !== 1'b1) begin errors++; $display("FAIL ar_pre got v=%b pc=%h exp v=1 pc=4", if_id_valid_inst, if_id_PC); end
    rst = 1'b1;
    #1;
    checks++; if (if_id_valid_inst !== 1'b0 || if_id_IR !== NOP || if_id_PC !== 32'h0 || imem_req !== 1'b0) begin
      errors++; $display("FAIL ar_async got v=%b ir=%h pc=%h req=%b exp v=0 ir=%h pc=0 req=0", if_id_valid_inst, if_id_IR, if_id_PC, imem_req, NOP);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL ar_restart got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr); end
    step();
    checks++; if (if_id_PC !== 32'h0 || if_id_valid_inst !== 1'b1) begin errors++; $display("FAIL ar_first got v=%b pc=%h exp v=1 pc=0", if_id_valid_inst, if_id_PC); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    wcnt = 0;
    test_reset();
    test_zero_wait();
    test_wait2();
    test_stall();
    test_redirect_drain();
    test_redirect_stall();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction Fetch stage and IF/ID pipeline register, directly upstream of id_stage.
- Holds the fetch PC and issues single-outstanding requests to instruction memory over a req/valid handshake.
- Drives if_id_IR, if_id_PC and if_id_valid_inst into decode.
- Honours stalls from the hazard unit with a one-entry skid buffer.
- Flushes and redirects on taken branches/jumps.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC loaded on reset
NOP_INST, 32'h0000_0013, value driven on if_id_IR whenever if_id_valid_inst=0 (addi x0,x0,0)

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
stall  in  1  hold IF/ID contents (d_hazard_detected from id_stage)
redirect_en  in  1  taken branch/jump resolved; flush and refetch
redirect_pc  in  32  redirect target
imem_req  out  1  fetch request
imem_addr  out  32  fetch address (word aligned)
imem_valid  in  1  response valid; completes a transaction when imem_req=1 in the same cycle
imem_data  in  32  instruction, sampled on completion
if_id_IR  out  32  instruction to decode
if_id_PC  out  32  PC of if_id_IR
if_id_valid_inst  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (async):
  - fetch_pc=RESET_PC, FSM=RUN, skid empty.
  - if_id_IR=NOP_INST, if_id_PC=0, if_id_valid_inst=0.
  - imem_req=0 while rst is high. First request is at RESET_PC in the first cycle after deassertion.
- Handshake:
  - A transaction completes on the clock edge where imem_req & imem_valid.
  - Zero-wait responses (imem_valid in the first cycle of req) are legal.
  - While imem_req=1 and not complete, imem_req and imem_addr stay stable.
  - imem_valid is ignored when imem_req=0.
- imem_req and imem_addr are driven only from registers.
  - imem_req = !rst & !skid_full.
  - imem_addr = DRAIN ? drain_addr : fetch_pc.
- FSM states:
  - RUN: normal fetch.
  - DRAIN: finishing a stale in-flight fetch after a redirect.
- Per-edge priority: redirect_en > stall > normal.
- Redirect (redirect_en=1):
  - IF/ID flushed: valid=0, IR=NOP_INST, PC unchanged.
  - Skid cleared; fetch_pc<=redirect_pc.
  - If a request is outstanding and not completing this cycle: drain_addr<=current imem_addr, go to DRAIN.
  - If the request is completing this cycle: its data is dropped and the FSM stays in RUN.
  - Redirect overrides a simultaneous stall.
  - A redirect while in DRAIN updates fetch_pc only; the FSM stays in DRAIN.
- DRAIN:
  - The response that completes the transaction is discarded.
  - Go to RUN; the next cycle requests fetch_pc.
  - IF/ID valid stays 0 throughout.
- Stall (no redirect):
  - IF/ID holds all fields.
  - A completion while in RUN goes into the skid (inst, pc) and sets fetch_pc+=4.
  - While the skid is full, imem_req=0.
- Normal (no stall, no redirect), RUN:
  - If the skid is full: IF/ID<=skid, valid=1, skid empties.
  - Else if a completion occurs: IF/ID<={imem_data, fetch_pc, 1}, fetch_pc+=4.
  - Else: bubble (valid=0, IR=NOP_INST).
- Arithmetic:
  - fetch_pc+4 wraps modulo 2^32.
  - redirect_pc[1:0] is forced to 0.

Optional Feature:
IF_PERF_EN.
- Defined: adds outputs if_fetch_cnt (32, completed non-discarded fetches) and if_bubble_cnt (32, cycles with if_id_valid_inst=0 after reset).
  - Both counters are async-reset to 0 and wrap at 2^32.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then zero-wait memory (imem_valid=1 constantly) → if_id_PC 0,4,8,... on consecutive cycles with valid=1; IR matches memory contents.
- Memory with 2 wait cycles → imem_addr stable across waits; IF/ID shows a valid instruction every 3rd cycle and NOP_INST bubbles between.
- stall=1 for 3 cycles with zero-wait memory → IF/ID frozen; exactly one extra fetch is captured in the skid and imem_req=0 while it is full.
  - On release, the skid PC appears next cycle, followed by PC+4.
- redirect_en with redirect_pc=0x100 while a 3-cycle fetch of 0x20 is outstanding → imem_addr stays 0x20 until imem_valid; its data is discarded.
  - Next request is 0x100, and IF/ID valid=0 until the 0x100 instruction arrives.
- redirect_en and stall both high with a full skid → skid and IF/ID flushed; next fetch is redirect_pc.
- rst asserted mid-transaction → outputs return to reset values immediately (async); fetch restarts at RESET_PC after deassertion.
